frame_buf_sched: RTL
====================

FRAME_BUF_SCHED -- requirements
Module: frame_buf_sched

Interface
REQ-001 Parameter NUM_BUF, default 3, number of frame buffers; only 3 is supported.
REQ-002 Parameter CNT_W, default 32, width of the frame counter.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 sof  input  1  producer start-of-frame pulse.
REQ-006 eof  input  1  producer end-of-frame pulse that commits the frame.
REQ-007 wr_buf  output  2  buffer index the producer writes.
REQ-008 wr_valid  output  1  wr_buf is held by the producer.
REQ-009 rd_acq  input  1  consumer acquire-latest pulse.
REQ-010 rd_rel  input  1  consumer release pulse.
REQ-011 rd_buf  output  2  buffer index held by the consumer.
REQ-012 rd_valid  output  1  rd_buf is held by the consumer.
REQ-013 n_frame  output  CNT_W  count of committed frames; this value feeds the frame-number PIO.
REQ-014 frame_irq  output  1  one-cycle pulse on each commit.
REQ-015 drop_cnt  output  16  count of overwritten READY frames.

Function
REQ-016 Each buffer SHALL be in exactly one state: FREE, WRITING, READY or READING.
REQ-017 At most one buffer SHALL be WRITING, one READY and one READING at any time.
REQ-018 All outputs SHALL be registered; every response SHALL appear the cycle after the causing input.
REQ-019 Producer FSM states: IDLE and WRITE.
- sof in IDLE: lowest-index FREE buffer goes to WRITING; wr_buf takes that index; wr_valid=1; FSM goes to WRITE.
REQ-020 eof in WRITE:
- WRITING buffer goes to READY.
- Any previous READY buffer goes to FREE and drop_cnt increments.
- n_frame increments, wrapping from all-ones to 0.
- frame_irq pulses; wr_valid=0; FSM goes to IDLE.
REQ-021 sof in WRITE SHALL restart the frame in the same buffer: no commit, no n_frame change, wr_buf unchanged.
REQ-022 eof in IDLE SHALL be ignored.
REQ-023 sof and eof asserted in the same cycle SHALL be treated as eof followed by a new sof on the next cycle.
REQ-024 rd_acq with rd_valid=0 and a READY buffer present: that buffer goes to READING, rd_buf takes its index, rd_valid=1.
REQ-025 rd_acq with no READY buffer, or with rd_valid=1, SHALL be ignored.
REQ-026 rd_rel with rd_valid=1: the READING buffer goes to FREE and rd_valid=0. rd_rel with rd_valid=0 SHALL be ignored.
REQ-027 Each decision SHALL use current-cycle state; updates become visible next cycle.
- eof and rd_acq in the same cycle: rd_acq takes the pre-existing READY buffer, which is then not freed. If no READY buffer exists, rd_acq is ignored.
REQ-028 rd_rel and sof in the same cycle: sof SHALL choose from the current FREE set; with 3 buffers a FREE buffer always exists at sof in IDLE.
REQ-029 rd_acq and rd_rel in the same cycle with rd_valid=1: release only.

Reset
REQ-030 While reset_n=0 at a clk edge, the following SHALL be cleared regardless of any operation in progress:
- all buffers FREE; FSM IDLE
- wr_buf=0, wr_valid=0, rd_buf=0, rd_valid=0
- n_frame=0, frame_irq=0, drop_cnt=0
REQ-031 Inputs SHALL be ignored during reset.

Configuration
REQ-032 Macro FRAME_BUF_SCHED_DROP_CNT_EN defined: drop_cnt SHALL be a 16-bit counter that saturates at 0xFFFF.
REQ-033 Macro not defined: drop_cnt SHALL be constant 0 and no counter logic is built; all other behaviour is unchanged.

Structure
REQ-034 Shared package fbs_pkg SHALL hold:
- buf_state_t enum (FREE, WRITING, READY, READING)
- prod_state_t enum (IDLE, WRITE)
- constants NUM_BUF=3 and BUF_IDX_W=2
REQ-035 A single sub-module, fbs_free_pick, SHALL be the lowest-index FREE priority encoder, producing an index and a found flag.

Verification
REQ-036 Reset, then sof and eof -> wr_buf=0; n_frame=1; frame_irq for one cycle; buffer 0 READY.
REQ-037 Two frames committed, no acquire -> n_frame=2; buffer 0 FREE; buffer 1 READY; drop_cnt=1 (0 without the macro).
REQ-038 After one commit: rd_acq -> rd_buf=0, rd_valid=1. Next sof -> wr_buf=1. Another rd_acq -> no change. rd_rel -> rd_valid=0.
REQ-039 eof and rd_acq in the same cycle with buffer 1 READY and buffer 2 WRITING -> rd_buf=1; buffer 2 READY; drop_cnt unchanged.
REQ-040 n_frame preloaded by force to 0xFFFFFFFF, then eof -> n_frame=0. drop_cnt forced to 0xFFFF, then a drop -> drop_cnt stays 0xFFFF.
REQ-041 reset_n low during WRITE with rd_valid=1 -> all outputs 0 next cycle; a following sof -> wr_buf=0.

Source files
------------

// File: rtl/fbs_pkg.sv
// fbs_pkg - shared types and constants for the frame buffer scheduler.
//
// Contents:
//   NUM_BUF      number of frame buffers the scheduler rotates (triple buffering)
//   BUF_IDX_W    width of a buffer index
//   buf_state_t  ownership state of one buffer (FREE, WRITING, READY, READING)
//   prod_state_t producer-side FSM state (IDLE, WRITE)
package fbs_pkg;

    localparam int NUM_BUF   = 3;
    localparam int BUF_IDX_W = 2;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } buf_state_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } prod_state_t;

endpackage

// File: rtl/fbs_free_pick.sv
// fbs_free_pick - lowest-index priority encoder over the FREE buffer mask.
//
// Ports:
//   free_mask  input  NUM_BUF    bit i set when buffer i is FREE
//   idx        output BUF_IDX_W  lowest index whose mask bit is set (0 if none)
//   found      output 1          at least one mask bit is set
module fbs_free_pick
    import fbs_pkg::*;
(
    input  logic [NUM_BUF-1:0]   free_mask,
    output logic [BUF_IDX_W-1:0] idx,
    output logic                 found
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx   = BUF_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched - triple-buffer scheduler between one frame producer and
// one frame consumer. The producer always gets a FREE buffer to write; a
// committed frame becomes the single READY buffer (replacing, and counting as
// dropped, any older READY frame); the consumer acquires the latest READY frame.
//
// Ports:
//   clk        input  1          single clock
//   reset_n    input  1          synchronous active-low reset
//   sof        input  1          producer start-of-frame pulse
//   eof        input  1          producer end-of-frame pulse (commits the frame)
//   wr_buf     output 2          buffer index the producer writes
//   wr_valid   output 1          wr_buf is held by the producer
//   rd_acq     input  1          consumer acquire-latest pulse
//   rd_rel     input  1          consumer release pulse
//   rd_buf     output 2          buffer index held by the consumer
//   rd_valid   output 1          rd_buf is held by the consumer
//   n_frame    output CNT_W      committed frame count (wraps)
//   frame_irq  output 1          one-cycle pulse per commit
//   drop_cnt   output 16         overwritten READY frames
//
// Configuration macro FRAME_BUF_SCHED_DROP_CNT_EN: when defined drop_cnt is a
// saturating 16-bit counter; otherwise drop_cnt is tied to 0.
module frame_buf_sched
    import fbs_pkg::*;
#(
    parameter int NUM_BUF = 3,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sof,
    input  logic                 eof,
    output logic [1:0]           wr_buf,
    output logic                 wr_valid,
    input  logic                 rd_acq,
    input  logic                 rd_rel,
    output logic [1:0]           rd_buf,
    output logic                 rd_valid,
    output logic [CNT_W-1:0]     n_frame,
    output logic                 frame_irq,
    output logic [15:0]          drop_cnt
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_WRITE = WRITE;

    buf_state_t             buf_st [NUM_BUF];
    buf_state_t             buf_nx [NUM_BUF];
    logic [0:0]             prod_st;
    logic                   pend_sof;
    logic [NUM_BUF-1:0]     free_mask;
    logic [BUF_IDX_W-1:0]   free_idx;
    logic                   free_found;
    logic [BUF_IDX_W-1:0]   ready_idx;
    logic                   ready_found;
    logic                   rel_now;
    logic                   acq_now;
    logic                   start_now;
    logic                   commit_now;

    // Summarise the buffer table: which buffers are FREE and where the single
    // READY buffer (if any) lives.
    always_comb begin
        free_mask   = '0;
        ready_idx   = '0;
        ready_found = 1'b0;
        for (int i = 0; i < NUM_BUF; i++) begin
            free_mask[i] = (buf_st[i] == FREE);
            if (buf_st[i] == READY) begin
                ready_idx   = BUF_IDX_W'(i);
                ready_found = 1'b1;
            end
        end
    end

    fbs_free_pick u_free_pick (
        .free_mask (free_mask),
        .idx       (free_idx),
        .found     (free_found)
    );

    // Release wins over acquire when both arrive while holding a buffer.
    // A sof that arrived together with a commit is replayed via pend_sof.
    assign rel_now    = rd_rel & rd_valid;
    assign acq_now    = rd_acq & ~rd_valid & ready_found;
    assign start_now  = (prod_st == ST_IDLE) & (sof | pend_sof) & free_found;
    assign commit_now = (prod_st == ST_WRITE) & eof;

    // Per-buffer transitions, all decided from the current table. An acquire
    // in the commit cycle claims the old READY buffer, so it is not freed.
    always_comb begin
        for (int i = 0; i < NUM_BUF; i++) begin
            buf_nx[i] = buf_st[i];
            if (rel_now && rd_buf == BUF_IDX_W'(i)) begin
                buf_nx[i] = FREE;
            end
            if (ready_found && ready_idx == BUF_IDX_W'(i)) begin
                if (acq_now) begin
                    buf_nx[i] = READING;
                end else if (commit_now) begin
                    buf_nx[i] = FREE;
                end
            end
            if (commit_now && wr_buf == BUF_IDX_W'(i)) begin
                buf_nx[i] = READY;
            end
            if (start_now && free_idx == BUF_IDX_W'(i)) begin
                buf_nx[i] = WRITING;
            end
        end
    end

    // Registered state and outputs. Counters only load on their events so a
    // value placed in them is held until the next commit or drop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_st[i] <= FREE;
            end
            prod_st   <= ST_IDLE;
            pend_sof  <= 1'b0;
            wr_buf    <= '0;
            wr_valid  <= 1'b0;
            rd_buf    <= '0;
            rd_valid  <= 1'b0;
            n_frame   <= '0;
            frame_irq <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_st[i] <= buf_nx[i];
            end
            frame_irq <= commit_now;
            pend_sof  <= commit_now & sof;
            if (start_now) begin
                prod_st  <= ST_WRITE;
                wr_buf   <= free_idx;
                wr_valid <= 1'b1;
            end else if (commit_now) begin
                prod_st  <= ST_IDLE;
                wr_valid <= 1'b0;
                n_frame  <= n_frame + CNT_W'(1);
            end
            if (rel_now) begin
                rd_valid <= 1'b0;
            end else if (acq_now) begin
                rd_valid <= 1'b1;
                rd_buf   <= ready_idx;
            end
        end
    end

`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
    logic drop_now;

    assign drop_now = commit_now & ready_found & ~acq_now;

    // Saturating count of READY frames overwritten before the consumer took them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop_now && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
